alu_mc: RTL

Multi-cycle, width-parameterised ALU for the multi-cycle CPU datapath. It keeps the existing single-cycle operation encoding: AND, OR, ADD, SUB, SLT and NOR. It adds two iterative operations: unsigned multiply (shift-add) and unsigned divide (restoring). Operands are accepted with a valid/ready handshake, and every result is registered and announced with a one-cycle done pulse. It sits between the register-read stage and the writeback mux; the control FSM stalls on ready_o.

---
 rtl/alu_mc_pkg.sv | 23 ++
 rtl/alu_mc_iter.sv | 81 ++++++++
 rtl/alu_mc.sv | 134 +++++++++++++
 3 files changed

// File: rtl/alu_mc_pkg.sv
// Shared op codes and FSM state encoding for the multi-cycle ALU.
// The DIV state only exists when ALU_MC_DIV_EN is defined.
package alu_mc_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_MULU = 4'd8;
    localparam logic [3:0] OP_DIVU = 4'd9;
    localparam logic [3:0] OP_NOR  = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
`ifdef ALU_MC_DIV_EN
        DIV  = 2'd2,
`endif
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_mc_iter.sv
// Shared shift engine: shift-add multiply and, with ALU_MC_DIV_EN, restoring divide.
// After WIDTH steps hi/lo hold product high/low or remainder/quotient.
module alu_mc_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef ALU_MC_DIV_EN
    input  logic             mode,
`endif
    input  logic             run,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc, q, m;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_n, q_n;
    logic [WIDTH:0]   mul_sum;
`ifdef ALU_MC_DIV_EN
    logic             div_mode;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
`endif

    always_comb begin
        // Multiply: add multiplicand when the low multiplier bit is set, then shift {acc,q} right.
        mul_sum = q[0] ? ({1'b0, acc} + {1'b0, m}) : {1'b0, acc};
        acc_n   = mul_sum[WIDTH:1];
        q_n     = {mul_sum[0], q[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
        // Divide: shift next dividend bit into the remainder and keep the trial difference on no borrow.
        // A zero divisor never borrows, yielding all-ones quotient and remainder equal to A.
        shifted = {acc, q[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, m};
        if (div_mode) begin
            if (!diff[WIDTH+1]) begin
                acc_n = diff[WIDTH-1:0];
                q_n   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = shifted[WIDTH-1:0];
                q_n   = {q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            q   <= '0;
            m   <= '0;
            cnt <= '0;
`ifdef ALU_MC_DIV_EN
            div_mode <= 1'b0;
`endif
        end else if (start) begin
            acc <= '0;
            q   <= a;
            m   <= b;
            cnt <= CNT_W'(WIDTH);
`ifdef ALU_MC_DIV_EN
            div_mode <= mode;
`endif
        end else if (run && cnt != '0) begin
            acc <= acc_n;
            q   <= q_n;
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_W'(1));
    assign hi   = acc;
    assign lo   = q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative MULU and (ALU_MC_DIV_EN) DIVU.
// Handshake: a request is accepted on a rising edge where valid_i && ready_o; done_o pulses once per result.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             div_zero_o,
    output state_t           dbg_state
);
    state_t           state;
    logic             accept, is_mul, start_iter, iterating, iter_last;
    logic [WIDTH-1:0] iter_hi, iter_lo;
    logic [WIDTH-1:0] sum, diff, simple_res;
    logic             simple_ovf;
`ifdef ALU_MC_DIV_EN
    logic             is_div, dz_pend;
    assign is_div     = (op_i == OP_DIVU);
    assign start_iter = accept && (is_mul || is_div);
    assign iterating  = (state == MUL) || (state == DIV);
`else
    assign start_iter = accept && is_mul;
    assign iterating  = (state == MUL);
`endif

    assign ready_o   = (state == IDLE);
    assign accept    = valid_i && ready_o;
    assign is_mul    = (op_i == OP_MULU);
    assign dbg_state = state;

    always_comb begin
        sum        = src1_i + src2_i;
        diff       = src1_i - src2_i;
        simple_res = '0;
        simple_ovf = 1'b0;
        case (op_i)
            OP_AND: simple_res = src1_i & src2_i;
            OP_OR:  simple_res = src1_i | src2_i;
            OP_ADD: begin
                simple_res = sum;
                simple_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SUB: begin
                simple_res = diff;
                simple_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (diff[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SLT: simple_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            OP_NOR: simple_res = ~(src1_i | src2_i);
            default: simple_res = '0;
        endcase
    end

    alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
        .clk   (clk_i),
        .rst   (rst_i),
        .start (start_iter),
`ifdef ALU_MC_DIV_EN
        .mode  (is_div),
`endif
        .run   (iterating),
        .a     (src1_i),
        .b     (src2_i),
        .last  (iter_last),
        .hi    (iter_hi),
        .lo    (iter_lo)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            done_o      <= 1'b0;
            result_o    <= '0;
            result_hi_o <= '0;
            zero_o      <= 1'b1;
            overflow_o  <= 1'b0;
            div_zero_o  <= 1'b0;
`ifdef ALU_MC_DIV_EN
            dz_pend     <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state <= MUL;
`ifdef ALU_MC_DIV_EN
                        end else if (is_div) begin
                            state   <= DIV;
                            dz_pend <= (src2_i == '0);
`endif
                        end else begin
                            done_o      <= 1'b1;
                            result_o    <= simple_res;
                            result_hi_o <= '0;
                            zero_o      <= (simple_res == '0);
                            overflow_o  <= simple_ovf;
                            div_zero_o  <= 1'b0;
                        end
                    end
                end
                FIN: begin
                    state       <= IDLE;
                    done_o      <= 1'b1;
                    result_o    <= iter_lo;
                    result_hi_o <= iter_hi;
                    zero_o      <= (iter_lo == '0);
                    overflow_o  <= 1'b0;
`ifdef ALU_MC_DIV_EN
                    div_zero_o  <= dz_pend;
`else
                    div_zero_o  <= 1'b0;
`endif
                end
                default: begin
                    if (iter_last) state <= FIN;
                end
            endcase
        end
    end

endmodule
